// File: rtl/aes_pkg.sv
// Shared AES types: the 128-bit block type and the output serializer states.
package aes_pkg;

  localparam int AES_BLK_W = 128;

  typedef logic [AES_BLK_W-1:0] aes_block_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

endpackage

// File: rtl/aes_outbuf_fifo.sv
// DEPTH-entry block FIFO that feeds the output serializer. DEPTH must be a power of two,
// so the pointers wrap naturally. A push and a pop on the same edge are allowed even when full.
module aes_outbuf_fifo
  import aes_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  aes_block_t                 wdata,
  output aes_block_t                 rdata,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  aes_block_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // NOTE: the storage array is deliberately not reset; level gates every read, so stale
  // contents can never reach the output and the array can map onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (level == LVL_W'(DEPTH));
  assign empty = (level == '0);

endmodule

// File: rtl/aes_output_buffer.sv
// AES output buffer: queues ciphertext blocks and streams them as WORD_W-bit words, MS word first.
// Optional macro AES_OUTBUF_OVF_CNT_EN enables a saturating dropped-block counter on ovf_cnt_o.
module aes_output_buffer
  import aes_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int WORD_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       done_i,
  input  logic [AES_BLK_W-1:0]       text_i,
  output logic                       accept_o,
  output logic [WORD_W-1:0]          dout_o,
  output logic                       dout_valid_o,
  output logic                       dout_last_o,
  input  logic                       dout_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic                       ovf_o,
  output logic [7:0]                 ovf_cnt_o
);

  localparam int NWORDS = AES_BLK_W / WORD_W;
  localparam int WIDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  ser_state_t        state_q, state_d;
  aes_block_t        blk_q;
  aes_block_t        fifo_head;
  logic [WIDX_W-1:0] widx_q, widx_d;
  logic              fifo_push, fifo_pop;
  logic              fifo_full, fifo_empty;
  logic              is_last;
  logic              drop;

  aes_outbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (text_i),
    .rdata (fifo_head),
    .level (level_o),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A full FIFO still takes a block on the edge where the serializer pops its head.
  assign accept_o  = ~fifo_full | fifo_pop;
  assign fifo_push = done_i & accept_o;
  assign drop      = done_i & ~accept_o;
  assign is_last   = (widx_q == WIDX_W'(NWORDS - 1));

  // NOTE: sequential state uses non-blocking assignments only, so every register samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      widx_q  <= '0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      widx_q  <= widx_d;
      if (fifo_pop) blk_q <= fifo_head;
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    widx_d   = widx_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          widx_d   = '0;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (dout_ready_i) begin
          if (!is_last) begin
            widx_d = widx_q + 1'b1;
          end else if (!fifo_empty) begin
            // Chain straight into the next block so back-to-back blocks have no bubble.
            fifo_pop = 1'b1;
            widx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Valid is a pure function of state, never of ready.
  always_comb begin
    dout_valid_o = 1'b0;
    dout_last_o  = 1'b0;
    dout_o       = '0;
    if (state_q == SEND) begin
      dout_valid_o = 1'b1;
      dout_last_o  = is_last;
      dout_o       = blk_q[AES_BLK_W-1 - WORD_W*int'(widx_q) -: WORD_W];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      ovf_o <= 1'b0;
    else if (drop) ovf_o <= 1'b1;
  end

`ifdef AES_OUTBUF_OVF_CNT_EN
  logic [7:0] ovf_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                            ovf_cnt_q <= 8'h00;
    else if (drop && ovf_cnt_q != 8'hFF) ovf_cnt_q <= ovf_cnt_q + 8'd1;
  end

  assign ovf_cnt_o = ovf_cnt_q;
`else
  assign ovf_cnt_o = 8'h00;
`endif

endmodule

// File: tb/tb_aes_output_buffer.sv
// Self-checking bench for aes_output_buffer: directed scenarios plus a randomized stream
// scored against a word-level queue model of the expected output.
module tb_aes_output_buffer;

  localparam int DEPTH  = 4;
  localparam int WORD_W = 32;
  localparam int NW     = 128 / WORD_W;

  localparam logic [127:0] VEC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
`ifdef AES_OUTBUF_OVF_CNT_EN
  localparam logic [7:0] EXP_CNT1 = 8'd1;
`else
  localparam logic [7:0] EXP_CNT1 = 8'd0;
`endif

  logic              clk;
  logic              rst;
  logic              done_i;
  logic [127:0]      text_i;
  logic              accept_o;
  logic [WORD_W-1:0] dout_o;
  logic              dout_valid_o;
  logic              dout_last_o;
  logic              dout_ready_i;
  logic [2:0]        level_o;
  logic              ovf_o;
  logic [7:0]        ovf_cnt_o;

  typedef struct {
    logic [WORD_W-1:0] word;
    logic              last;
  } exp_word_t;

  exp_word_t exp_q[$];
  exp_word_t mon_e;
  int        checks   = 0;
  int        failures = 0;

  aes_output_buffer #(.DEPTH(DEPTH), .WORD_W(WORD_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .done_i       (done_i),
    .text_i       (text_i),
    .accept_o     (accept_o),
    .dout_o       (dout_o),
    .dout_valid_o (dout_valid_o),
    .dout_last_o  (dout_last_o),
    .dout_ready_i (dout_ready_i),
    .level_o      (level_o),
    .ovf_o        (ovf_o),
    .ovf_cnt_o    (ovf_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stream scoreboard: every accepted word must be the oldest outstanding expected word.
  always @(negedge clk) begin
    if (rst && dout_valid_o && dout_ready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL stream_extra: got word %h last %b, expected no word", dout_o, dout_last_o);
      end else begin
        mon_e = exp_q.pop_front();
        if (dout_o !== mon_e.word || dout_last_o !== mon_e.last) begin
          failures++;
          $display("FAIL stream_word: got %h last %b, expected %h last %b",
                   dout_o, dout_last_o, mon_e.word, mon_e.last);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // A stored block becomes NW words, most significant first, the final one flagged last.
  task automatic model_push(input logic [127:0] b);
    exp_word_t e;
    for (int i = 0; i < NW; i++) begin
      e.word = WORD_W'(b >> (128 - WORD_W * (i + 1)));
      e.last = (i == NW - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse(input logic [127:0] b, input bit store);
    done_i = 1'b1;
    text_i = b;
    if (store) model_push(b);
    next_cycle();
    done_i = 1'b0;
  endtask

  task automatic do_reset();
    done_i       = 1'b0;
    dout_ready_i = 1'b0;
    text_i       = '0;
    rst          = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    next_cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1; done_i = 1'b0; dout_ready_i = 1'b0; text_i = '0;
    #2 rst = 1'b0;
    #1;
    checks++; if (level_o !== 3'd0)     begin failures++; $display("FAIL reset_level: got %0d expected 0", level_o); end
    checks++; if (accept_o !== 1'b1)    begin failures++; $display("FAIL reset_accept: got %b expected 1", accept_o); end
    checks++; if (dout_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", dout_valid_o); end
    checks++; if (dout_last_o !== 1'b0) begin failures++; $display("FAIL reset_last: got %b expected 0", dout_last_o); end
    checks++; if (dout_o !== '0)        begin failures++; $display("FAIL reset_dout: got %h expected 0", dout_o); end
    checks++; if (ovf_o !== 1'b0)       begin failures++; $display("FAIL reset_ovf: got %b expected 0", ovf_o); end
    checks++; if (ovf_cnt_o !== 8'h00)  begin failures++; $display("FAIL reset_ovf_cnt: got %h expected 00", ovf_cnt_o); end
    @(negedge clk);
    rst = 1'b1;
    next_cycle();
  endtask

  task automatic test_single();
    do_reset();
    dout_ready_i = 1'b1;
    done_i = 1'b1; text_i = VEC; model_push(VEC);
    @(negedge clk);
    checks++; if (accept_o !== 1'b1) begin failures++; $display("FAIL single_accept: got %b expected 1", accept_o); end
    next_cycle();
    done_i = 1'b0;
    @(negedge clk);
    checks++; if (dout_valid_o !== 1'b0) begin failures++; $display("FAIL single_valid_t1: got %b expected 0", dout_valid_o); end
    checks++; if (level_o !== 3'd1)      begin failures++; $display("FAIL single_level_t1: got %0d expected 1", level_o); end
    next_cycle();
    @(negedge clk);
    checks++; if (dout_valid_o !== 1'b1 || dout_o !== 32'h69c4e0d8)
      begin failures++; $display("FAIL single_first_word: got valid %b word %h expected valid 1 word 69c4e0d8", dout_valid_o, dout_o); end
    for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(negedge clk);
    next_cycle();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL single_drain: got %0d words pending expected 0", exp_q.size()); end
    @(negedge clk);
    checks++; if (dout_valid_o !== 1'b0) begin failures++; $display("FAIL single_idle_after: got valid %b expected 0", dout_valid_o); end
  endtask

  task automatic test_backpressure();
    do_reset();
    pulse(VEC, 1'b1);
    next_cycle();
    @(negedge clk);
    checks++; if (dout_valid_o !== 1'b1 || dout_o !== 32'h69c4e0d8)
      begin failures++; $display("FAIL bp_hold_w0: got valid %b word %h expected valid 1 word 69c4e0d8", dout_valid_o, dout_o); end
    next_cycle();
    dout_ready_i = 1'b1;
    next_cycle();
    dout_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (dout_valid_o !== 1'b1 || dout_o !== 32'h6a7b0430 || dout_last_o !== 1'b0)
        begin failures++; $display("FAIL bp_hold_w1: cycle %0d got valid %b word %h last %b expected 1 6a7b0430 0", i, dout_valid_o, dout_o, dout_last_o); end
      next_cycle();
    end
    dout_ready_i = 1'b1;
    for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(negedge clk);
    next_cycle();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL bp_drain: got %0d words pending expected 0", exp_q.size()); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 5; i++) pulse(rand_blk(), 1'b1);
    @(negedge clk);
    checks++; if (level_o !== 3'd4)       begin failures++; $display("FAIL fill_level: got %0d expected 4", level_o); end
    checks++; if (accept_o !== 1'b0)      begin failures++; $display("FAIL fill_accept: got %b expected 0", accept_o); end
    checks++; if (dout_valid_o !== 1'b1)  begin failures++; $display("FAIL fill_serializer_busy: got valid %b expected 1", dout_valid_o); end
    checks++; if (ovf_o !== 1'b0)         begin failures++; $display("FAIL fill_no_ovf_yet: got %b expected 0", ovf_o); end
    next_cycle();
    pulse(rand_blk(), 1'b0);
    @(negedge clk);
    checks++; if (ovf_o !== 1'b1)         begin failures++; $display("FAIL fill_ovf: got %b expected 1", ovf_o); end
    checks++; if (ovf_cnt_o !== EXP_CNT1) begin failures++; $display("FAIL fill_ovf_cnt: got %h expected %h", ovf_cnt_o, EXP_CNT1); end
    checks++; if (level_o !== 3'd4)       begin failures++; $display("FAIL fill_level_after_drop: got %0d expected 4", level_o); end
    next_cycle();
    dout_ready_i = 1'b1;
    for (int c = 0; c < 100 && exp_q.size() != 0; c++) @(negedge clk);
    next_cycle();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL fill_drain: got %0d words pending expected 0", exp_q.size()); end
    checks++; if (ovf_o !== 1'b1)    begin failures++; $display("FAIL fill_ovf_sticky: got %b expected 1", ovf_o); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 3; i++) pulse(rand_blk(), 1'b1);
    next_cycle();
    next_cycle();
    dout_ready_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++; if (dout_valid_o !== 1'b1 || dout_last_o !== ((i % 4) == 3))
        begin failures++; $display("FAIL b2b_word%0d: got valid %b last %b expected valid 1 last %b", i, dout_valid_o, dout_last_o, ((i % 4) == 3)); end
      next_cycle();
    end
    @(negedge clk);
    checks++; if (dout_valid_o !== 1'b0) begin failures++; $display("FAIL b2b_end: got valid %b expected 0", dout_valid_o); end
    checks++; if (exp_q.size() != 0)     begin failures++; $display("FAIL b2b_drain: got %0d words pending expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    logic [127:0] a;
    logic [127:0] c;
    a = rand_blk();
    c = rand_blk();
    do_reset();
    pulse(a, 1'b1);
    pulse(rand_blk(), 1'b1);
    dout_ready_i = 1'b1;
    next_cycle();
    next_cycle();
    dout_ready_i = 1'b0;
    #1;
    checks++; if (dout_o !== a[63:32] || level_o !== 3'd1)
      begin failures++; $display("FAIL rmid_pre: got word %h level %0d expected word %h level 1", dout_o, level_o, a[63:32]); end
    rst = 1'b0;
    exp_q.delete();
    #1;
    checks++; if (dout_valid_o !== 1'b0) begin failures++; $display("FAIL rmid_valid: got %b expected 0", dout_valid_o); end
    checks++; if (level_o !== 3'd0)      begin failures++; $display("FAIL rmid_level: got %0d expected 0", level_o); end
    @(negedge clk);
    rst = 1'b1;
    next_cycle();
    dout_ready_i = 1'b1;
    pulse(c, 1'b1);
    next_cycle();
    @(negedge clk);
    checks++; if (dout_valid_o !== 1'b1 || dout_o !== c[127:96])
      begin failures++; $display("FAIL rmid_restart: got valid %b word %h expected valid 1 word %h", dout_valid_o, dout_o, c[127:96]); end
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clk);
    next_cycle();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rmid_drain: got %0d words pending expected 0", exp_q.size()); end
  endtask

  task automatic test_full_pop_same_edge();
    logic [127:0] b6;
    b6 = rand_blk();
    do_reset();
    for (int i = 0; i < 5; i++) pulse(rand_blk(), 1'b1);
    dout_ready_i = 1'b1;
    next_cycle();
    next_cycle();
    next_cycle();
    done_i = 1'b1; text_i = b6; model_push(b6);
    @(negedge clk);
    checks++; if (accept_o !== 1'b1 || dout_last_o !== 1'b1)
      begin failures++; $display("FAIL fullpop_accept: got accept %b last %b expected 1 1", accept_o, dout_last_o); end
    next_cycle();
    done_i = 1'b0;
    @(negedge clk);
    checks++; if (ovf_o !== 1'b0)   begin failures++; $display("FAIL fullpop_ovf: got %b expected 0", ovf_o); end
    checks++; if (level_o !== 3'd4) begin failures++; $display("FAIL fullpop_level: got %0d expected 4", level_o); end
    for (int c = 0; c < 100 && exp_q.size() != 0; c++) @(negedge clk);
    next_cycle();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL fullpop_drain: got %0d words pending expected 0", exp_q.size()); end
    checks++; if (ovf_o !== 1'b0)    begin failures++; $display("FAIL fullpop_ovf_end: got %b expected 0", ovf_o); end
  endtask

  // Random traffic where the producer honours accept_o, as the input buffer would.
  task automatic test_random();
    logic [127:0] b;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      dout_ready_i = ($urandom_range(3) != 0);
      #1;
      if ($urandom_range(2) == 0 && accept_o) begin
        b = rand_blk();
        done_i = 1'b1; text_i = b; model_push(b);
      end else begin
        done_i = 1'b0;
      end
      next_cycle();
    end
    done_i = 1'b0;
    dout_ready_i = 1'b1;
    for (int c = 0; c < 200 && exp_q.size() != 0; c++) @(negedge clk);
    next_cycle();
    checks++; if (exp_q.size() != 0)     begin failures++; $display("FAIL rand_drain: got %0d words pending expected 0", exp_q.size()); end
    checks++; if (ovf_o !== 1'b0)        begin failures++; $display("FAIL rand_ovf: got %b expected 0", ovf_o); end
    checks++; if (level_o !== 3'd0)      begin failures++; $display("FAIL rand_level_end: got %0d expected 0", level_o); end
    checks++; if (dout_valid_o !== 1'b0) begin failures++; $display("FAIL rand_valid_end: got %b expected 0", dout_valid_o); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected finish within 1 ms");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_fill();
    test_back_to_back();
    test_reset_mid();
    test_full_pop_same_edge();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
